// File: rtl/rs_pkg.sv
// Shared constants and state type for the RS(15,11) syndrome front end.
// Optional statistics counters in the controller are enabled with RS_SYN_STATS_EN.
package rs_pkg;

    localparam int SYM_W = 4;
    localparam int N_SYM = 15;
    localparam int K_SYM = 11;
    localparam int N_SYN = N_SYM - K_SYM;
    localparam int CNT_W = $clog2(N_SYM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // A zero mask discards the cell's previous value; all ones keeps it.
    localparam logic [SYM_W-1:0] MASK_CLR = 4'h0;
    localparam logic [SYM_W-1:0] MASK_ACC = 4'hF;

endpackage

// File: rtl/rs_syndrome_ctrl.sv
// Sequencer for the four GF(16) syndrome cells: streams a codeword in and holds the syndromes.
// Define RS_SYN_STATS_EN to add saturating word / errored-word counters.
module rs_syndrome_ctrl
    import rs_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET_GLOBAL,
    input  logic [SYM_W-1:0]       IN_SYMBOL,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [SYM_W-1:0]       CELL_IN,
    output logic [SYM_W-1:0]       CELL_CONTROL,
    input  logic [N_SYN*SYM_W-1:0] CELL_OUT,
    output logic [N_SYN*SYM_W-1:0] SYN_OUT,
    output logic                   SYN_VALID,
    input  logic                   SYN_READY,
    output logic                   SYN_NONZERO,
`ifdef RS_SYN_STATS_EN
    output logic [15:0]            STAT_WORDS,
    output logic [15:0]            STAT_ERR_WORDS,
`endif
    output logic                   ABORT
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             acc;
    logic             last_sym;
    logic             capture;

    assign IN_READY = (state != HOLD) | SYN_READY;
    assign acc      = IN_VALID & IN_READY;
    assign last_sym = (count == CNT_W'(N_SYM - 1));
    assign capture  = (state == ACCUM) & acc & last_sym;

    // Cells see the symbol in the same cycle it is accepted, so CELL_OUT already
    // includes the last symbol when it is captured.
    assign CELL_IN      = acc ? IN_SYMBOL : '0;
    assign CELL_CONTROL = (acc && count != '0) ? MASK_ACC : MASK_CLR;

    // NOTE: all state here updates with <= so every branch reads pre-edge values.
    always_ff @(posedge CLK or posedge RESET_GLOBAL) begin
        if (RESET_GLOBAL) begin
            state       <= IDLE;
            count       <= '0;
            SYN_OUT     <= '0;
            SYN_VALID   <= 1'b0;
            SYN_NONZERO <= 1'b0;
            ABORT       <= 1'b0;
        end else begin
            ABORT <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        count <= CNT_W'(1);
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (acc) begin
                        if (last_sym) begin
                            SYN_OUT     <= CELL_OUT;
                            SYN_NONZERO <= |CELL_OUT;
                            SYN_VALID   <= 1'b1;
                            count       <= '0;
                            state       <= HOLD;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        // The cells free-run, so a gap corrupts the word; drop it.
                        ABORT <= 1'b1;
                        count <= '0;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (SYN_VALID && SYN_READY) begin
                        SYN_VALID <= 1'b0;
                        if (acc) begin
                            count <= CNT_W'(1);
                            state <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RS_SYN_STATS_EN
    always_ff @(posedge CLK or posedge RESET_GLOBAL) begin
        if (RESET_GLOBAL) begin
            STAT_WORDS     <= '0;
            STAT_ERR_WORDS <= '0;
        end else if (capture) begin
            if (STAT_WORDS != 16'hFFFF)
                STAT_WORDS <= STAT_WORDS + 16'd1;
            if ((|CELL_OUT) && STAT_ERR_WORDS != 16'hFFFF)
                STAT_ERR_WORDS <= STAT_ERR_WORDS + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Self-checking bench: four GF(16) syndrome cells around the controller, random codewords
// checked against a power-sum syndrome model. Build with RS_SYN_STATS_EN to cover the counters.
module tb_rs_syndrome_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_GLOBAL = 1'b1;
    logic [3:0]  IN_SYMBOL = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [3:0]  CELL_IN;
    logic [3:0]  CELL_CONTROL;
    logic [15:0] CELL_OUT;
    logic [15:0] SYN_OUT;
    logic        SYN_VALID;
    logic        SYN_READY = 1'b0;
    logic        SYN_NONZERO;
    logic        ABORT;
`ifdef RS_SYN_STATS_EN
    logic [15:0] STAT_WORDS;
    logic [15:0] STAT_ERR_WORDS;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_words = 0;
    int exp_err_words = 0;

    always #5 CLK = ~CLK;

    rs_syndrome_ctrl dut (
        .CLK          (CLK),
        .RESET_GLOBAL (RESET_GLOBAL),
        .IN_SYMBOL    (IN_SYMBOL),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .CELL_IN      (CELL_IN),
        .CELL_CONTROL (CELL_CONTROL),
        .CELL_OUT     (CELL_OUT),
        .SYN_OUT      (SYN_OUT),
        .SYN_VALID    (SYN_VALID),
        .SYN_READY    (SYN_READY),
        .SYN_NONZERO  (SYN_NONZERO),
`ifdef RS_SYN_STATS_EN
        .STAT_WORDS     (STAT_WORDS),
        .STAT_ERR_WORDS (STAT_ERR_WORDS),
`endif
        .ABORT        (ABORT)
    );

    // GF(2^4) with primitive polynomial x^4 + x + 1, alpha = 2.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = '0;
        logic [3:0] x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_pow(input int e);
        logic [3:0] r = 4'h1;
        for (int i = 0; i < e; i++) r = gf_mul(r, 4'h2);
        return r;
    endfunction

    // Syndrome cell j: reg <= (reg & mask) * alpha^(j+1) ^ in, output is the next value.
    logic [3:0] cell_reg [4];
    always_comb begin
        CELL_OUT = '0;
        for (int j = 0; j < 4; j++)
            CELL_OUT[4*j +: 4] = gf_mul(cell_reg[j] & CELL_CONTROL, gf_pow(j + 1)) ^ CELL_IN;
    end
    always_ff @(posedge CLK or posedge RESET_GLOBAL) begin
        for (int j = 0; j < 4; j++)
            cell_reg[j] <= RESET_GLOBAL ? 4'h0 : CELL_OUT[4*j +: 4];
    end

    // Reference: S_j = sum r_i * alpha^((j+1)*(14-i)), symbol 0 is the highest-order coefficient.
    function automatic logic [15:0] ref_syn(input logic [59:0] w);
        logic [15:0] s = '0;
        for (int j = 0; j < 4; j++) begin
            logic [3:0] acc_s = '0;
            for (int i = 0; i < 15; i++)
                acc_s = acc_s ^ gf_mul(w[4*i +: 4], gf_pow(((j + 1) * (14 - i)) % 15));
            s[4*j +: 4] = acc_s;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_syn_out"}, 32'(SYN_OUT), 32'h0);
        check({tag, "_syn_valid"}, 32'(SYN_VALID), 32'h0);
        check({tag, "_syn_nonzero"}, 32'(SYN_NONZERO), 32'h0);
        check({tag, "_abort"}, 32'(ABORT), 32'h0);
        check({tag, "_cell_in"}, 32'(CELL_IN), 32'h0);
        check({tag, "_cell_ctrl"}, 32'(CELL_CONTROL), 32'h0);
`ifdef RS_SYN_STATS_EN
        check({tag, "_stat_words"}, 32'(STAT_WORDS), 32'h0);
        check({tag, "_stat_err"}, 32'(STAT_ERR_WORDS), 32'h0);
`endif
    endtask

    task automatic do_reset();
        IN_VALID = 1'b0;
        RESET_GLOBAL = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_words = 0;
        exp_err_words = 0;
        @(negedge CLK);
        RESET_GLOBAL = 1'b0;
        step();
        check("rst_in_ready", 32'(IN_READY), 32'h1);
    endtask

    task automatic drive_sym(input int idx, input logic [3:0] sym);
        IN_VALID  = 1'b1;
        IN_SYMBOL = sym;
        @(negedge CLK);
        check("in_ready", 32'(IN_READY), 32'h1);
        check("cell_ctrl", 32'(CELL_CONTROL), (idx == 0) ? 32'h0 : 32'hF);
        check("cell_in", 32'(CELL_IN), 32'(sym));
        if (idx == 14) check("valid_before_last", 32'(SYN_VALID), 32'h0);
        step();
    endtask

    // Sends a full word; returns at posedge+1 one cycle after the capture edge.
    task automatic send_word(input logic [59:0] w);
        logic [15:0] exp_s;
        exp_s = ref_syn(w);
        for (int i = 0; i < 15; i++) drive_sym(i, w[4*i +: 4]);
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("syn_valid", 32'(SYN_VALID), 32'h1);
        check("syn_out", 32'(SYN_OUT), 32'(exp_s));
        check("syn_nonzero", 32'(SYN_NONZERO), 32'(exp_s != 16'h0));
        if (exp_words < 16'hFFFF) exp_words++;
        if (exp_s != 16'h0 && exp_err_words < 16'hFFFF) exp_err_words++;
        step();
    endtask

    task automatic consume();
        SYN_READY = 1'b1;
        step();
        SYN_READY = 1'b0;
        @(negedge CLK);
        check("consumed_valid", 32'(SYN_VALID), 32'h0);
        check("consumed_in_ready", 32'(IN_READY), 32'h1);
        step();
    endtask

    function automatic logic [59:0] rand_word();
        logic [59:0] w;
        for (int i = 0; i < 15; i++) w[4*i +: 4] = 4'($urandom_range(0, 15));
        return w;
    endfunction

    initial begin
        logic [59:0] w1, w2;
        logic [15:0] s1;
        int gap;

        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESET_GLOBAL = 1'b0;
        step();

        // All-zero codeword.
        send_word('0);
        consume();

        // Zeros with a 1 in the lowest-order position gives 1 in every syndrome.
        w1 = '0;
        w1[59:56] = 4'h1;
        send_word(w1);
        check("last_one_syn", 32'(SYN_OUT), 32'h1111);
        consume();

        // Result held with downstream stalled, then released together with the next word.
        w1 = rand_word();
        w2 = rand_word();
        s1 = ref_syn(w1);
        send_word(w1);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("stall_in_ready", 32'(IN_READY), 32'h0);
            check("stall_syn_out", 32'(SYN_OUT), 32'(s1));
            check("stall_valid", 32'(SYN_VALID), 32'h1);
            step();
        end
        SYN_READY = 1'b1;
        send_word(w2);
        SYN_READY = 1'b0;
        @(negedge CLK);
        check("b2b_consumed", 32'(SYN_VALID), 32'h0);
        step();

        // Gap at symbol 7 drops the word.
        w1 = rand_word();
        for (int i = 0; i < 7; i++) drive_sym(i, w1[4*i +: 4]);
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("abort_not_yet", 32'(ABORT), 32'h0);
        step();
        @(negedge CLK);
        check("abort_pulse", 32'(ABORT), 32'h1);
        check("abort_no_valid", 32'(SYN_VALID), 32'h0);
        step();
        @(negedge CLK);
        check("abort_cleared", 32'(ABORT), 32'h0);
        check("abort_no_valid2", 32'(SYN_VALID), 32'h0);
        step();
        send_word(rand_word());
        consume();

        // Reset mid-word, then a clean word.
        w1 = rand_word();
        for (int i = 0; i < 5; i++) drive_sym(i, w1[4*i +: 4]);
        #2;
        do_reset();
        send_word(rand_word());
        consume();

        // Reset while holding an unconsumed result.
        send_word(rand_word());
        #2;
        do_reset();
        send_word(rand_word());
        consume();

        // Random words, idle gaps and downstream stalls; some single-error words.
        for (int k = 0; k < 10; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            w1 = (k % 3 == 0) ? 60'h0 : rand_word();
            if (k % 3 == 0 && k > 0) w1[4*$urandom_range(0, 14) +: 4] = 4'($urandom_range(1, 15));
            send_word(w1);
            gap = $urandom_range(0, 3);
            for (int c = 0; c < gap; c++) begin
                @(negedge CLK);
                check("rand_hold_valid", 32'(SYN_VALID), 32'h1);
                step();
            end
            consume();
        end

`ifdef RS_SYN_STATS_EN
        // Three words, one of them errored, counted from a fresh reset.
        do_reset();
        send_word('0);
        consume();
        w1 = '0;
        w1[23:20] = 4'h9;
        send_word(w1);
        consume();
        send_word('0);
        consume();
        check("stat_words", 32'(STAT_WORDS), 32'(exp_words));
        check("stat_err_words", 32'(STAT_ERR_WORDS), 32'(exp_err_words));
        check("stat_words_3", 32'(STAT_WORDS), 32'd3);
        check("stat_err_words_1", 32'(STAT_ERR_WORDS), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_ctrl.md
Name: rs_syndrome_ctrl

Overview:
- Sequencer for the four GF(16) syndrome cells of the RS(15,11) decoder front end.
- Accepts a 15-symbol codeword over a valid/ready stream, feeds it to the cells and drives their per-cell feedback masks (clear on the first symbol).
- Captures the four syndromes on the last symbol and presents them, with a nonzero flag, on a valid/ready result port to the key-equation stage.

Parameters:
- SYM_W, 4, symbol width in bits (GF(2^4)).
- N_SYM, 15, symbols per codeword.
- N_SYN, 4, number of syndrome cells (N-K).

Ports:
- CLK  in  1  system clock.
- RESET_GLOBAL  in  1  asynchronous reset, active-high.
- IN_SYMBOL  in  SYM_W  received symbol, highest-order symbol first.
- IN_VALID  in  1  IN_SYMBOL valid.
- IN_READY  out  1  controller can accept a symbol.
- CELL_IN  out  SYM_W  symbol broadcast to all cells' IN_SERIAL.
- CELL_CONTROL  out  SYM_W  feedback mask broadcast to all cells' CONTROL.
- CELL_OUT  in  N_SYN*SYM_W  concatenated cell OUT_SERIAL; cell j is bits [4j+3:4j].
- SYN_OUT  out  N_SYN*SYM_W  captured syndromes, same packing.
- SYN_VALID  out  1  SYN_OUT holds a complete codeword's syndromes.
- SYN_READY  in  1  downstream accepts SYN_OUT.
- SYN_NONZERO  out  1  OR of all SYN_OUT bits, valid with SYN_VALID.
- ABORT  out  1  one-cycle pulse: codeword dropped because of a mid-word gap.

Behaviour:
- Reset values: state IDLE, count 0, SYN_OUT 0, SYN_VALID 0, SYN_NONZERO 0, ABORT 0. CELL_IN and CELL_CONTROL are combinational and evaluate to 0 in reset.
- Reset mid-word drops the partial word. Reset in HOLD drops the unconsumed result.
- Accept condition: acc = IN_VALID & IN_READY.
- IN_READY = (state != HOLD) | SYN_READY. This gives zero-bubble back-to-back words.
- Cell drive is combinational:
  - CELL_IN = acc ? IN_SYMBOL : 0.
  - CELL_CONTROL = 4'hF when acc and count != 0, else 4'h0.
  - A zero mask clears cell feedback, so the first symbol restarts accumulation.
- The cells clock every cycle with no enable, so symbols 1..N_SYM-1 of a word must arrive on consecutive cycles.
- States:
  - IDLE: on acc, count <= 1 and go to ACCUM.
  - ACCUM, acc with count == N_SYM-1: SYN_OUT <= CELL_OUT, SYN_NONZERO <= |CELL_OUT, SYN_VALID <= 1, count <= 0, go to HOLD.
  - ACCUM, acc otherwise: count <= count+1.
  - ACCUM, !IN_VALID: ABORT pulses 1 cycle, count <= 0, go to IDLE. No result is produced.
  - HOLD: SYN_OUT, SYN_VALID and SYN_NONZERO stay stable until SYN_VALID & SYN_READY.
  - HOLD, on handshake with no acc: SYN_VALID <= 0, go to IDLE.
  - HOLD, on handshake with acc the same cycle: that symbol is first symbol of the next word (mask 0), count <= 1, go to ACCUM.
- Latency: SYN_VALID rises the cycle after the 15th symbol is accepted.
- Count width: clog2(N_SYM+1). Count never exceeds N_SYM-1.

Optional Feature:
- Macro: RS_SYN_STATS_EN.
- Defined: adds outputs STAT_WORDS[15:0] and STAT_ERR_WORDS[15:0], both reset to 0.
  - STAT_WORDS increments on every capture into HOLD.
  - STAT_ERR_WORDS increments on captures with a nonzero syndrome.
  - Both counters saturate at 16'hFFFF.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package rs_pkg holds: SYM_W, N_SYM, K_SYM=11, N_SYN, the state typedef (IDLE/ACCUM/HOLD), and MASK_CLR=4'h0 / MASK_ACC=4'hF.
- No sub-module: the controller is a single FSM plus counter.
- The bench instantiates four syndrome cells around it.

Test Plan:
- All-zero codeword, 15 consecutive symbols:
  - SYN_OUT=16'h0000 and SYN_NONZERO=0.
  - SYN_VALID rises exactly 1 cycle after the 15th accept.
  - CELL_CONTROL=0 on symbol 0 and 4'hF on symbols 1..14.
- Zeros with last symbol = 4'h1 -> SYN_OUT=16'h1111, SYN_NONZERO=1.
- Hold SYN_READY=0 for 5 cycles after capture -> IN_READY=0 and SYN_OUT stable. Then SYN_READY=1 with IN_VALID=1 -> next word's first symbol accepted that cycle with mask 0. Two back-to-back valid words give correct syndromes for both.
- IN_VALID low at symbol 7 -> ABORT pulses once, no SYN_VALID. A following clean word yields correct syndromes.
- Assert RESET_GLOBAL asynchronously mid-word and again in HOLD -> all outputs return to reset values immediately. The next word processes normally.
- With RS_SYN_STATS_EN, feed 3 words (1 with error) -> STAT_WORDS=3, STAT_ERR_WORDS=1.
